// File: rtl/product_field_reg_if.sv
// Bus bundle for product_field_reg: field-write, commit and staging-read
// requests toward the register, and its field/status outputs back.
interface product_field_reg_if #(
    parameter int N = 2,
    parameter int W = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic              wr_valid;
    logic [IW-1:0]     wr_idx;
    logic [W-1:0]      wr_data;
    logic              commit;
    logic [IW-1:0]     rd_idx;
    logic [N*W-1:0]    O;
    logic [W-1:0]      rd_data;
    logic [N-1:0]      dirty;
    logic              commit_done;
    logic              idx_err;

    modport master (
        output wr_valid, wr_idx, wr_data, commit, rd_idx,
        input  O, rd_data, dirty, commit_done, idx_err
    );

    modport slave (
        input  wr_valid, wr_idx, wr_data, commit, rd_idx,
        output O, rd_data, dirty, commit_done, idx_err
    );
endinterface

// File: rtl/product_field_reg.sv
// Double-banked product field register: fields are written individually
// into a staging bank and copied to the active bank all at once on commit.
module product_field_reg #(
    parameter int          N      = 2,
    parameter int          W      = 8,
    parameter logic [W-1:0] INIT  = '0,
    parameter int          BYPASS = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    product_field_reg_if.slave   bus
);
    localparam int            IW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW:0]   NUM = (IW + 1)'(N);

    logic [N-1:0][W-1:0] stage;
    logic [N-1:0][W-1:0] stage_nxt;
    logic [N-1:0][W-1:0] active;
    logic [N-1:0][W-1:0] active_nxt;
    logic [N-1:0]        dirty_q;
    logic [N-1:0]        dirty_nxt;
    logic                commit_done_q;
    logic                idx_err_q;
    logic [W-1:0]        rd_data_q;
    logic                wr_ok;
    logic                rd_ok;
    logic                wr_fire;

    assign wr_ok   = {1'b0, bus.wr_idx} < NUM;
    assign rd_ok   = {1'b0, bus.rd_idx} < NUM;
    assign wr_fire = bus.wr_valid && wr_ok;

    // Next-state of both banks and the dirty mask; a commit takes the
    // staging bank including any same-cycle write, so writes merge through.
    always_comb begin
        stage_nxt  = stage;
        active_nxt = active;
        dirty_nxt  = dirty_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (wr_fire && (bus.wr_idx == IW'(i))) begin
                stage_nxt[i] = bus.wr_data;
                dirty_nxt[i] = 1'b1;
            end
        end
        if (bus.commit) begin
            active_nxt = stage_nxt;
            dirty_nxt  = '0;
        end
    end

    // Bank, flag and read-port registers; reset discards any pending write or commit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stage         <= {N{INIT}};
            active        <= {N{INIT}};
            dirty_q       <= '0;
            commit_done_q <= 1'b0;
            idx_err_q     <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            stage         <= stage_nxt;
            active        <= active_nxt;
            dirty_q       <= dirty_nxt;
            commit_done_q <= bus.commit;
            idx_err_q     <= idx_err_q | (bus.wr_valid & ~wr_ok) | ~rd_ok;
            rd_data_q     <= rd_ok ? stage_nxt[bus.rd_idx] : '0;
        end
    end

    // Field output: either the value active is about to take, or active itself.
    generate
        if (BYPASS != 0) begin : g_bypass
            assign bus.O = RESET ? {N{INIT}} : active_nxt;
        end else begin : g_registered
            assign bus.O = active;
        end
    endgenerate

    assign bus.rd_data     = rd_data_q;
    assign bus.dirty       = dirty_q;
    assign bus.commit_done = commit_done_q;
    assign bus.idx_err     = idx_err_q;
endmodule

// File: doc/product_field_reg.md
PRODUCT_FIELD_REG -- requirements
Module: product_field_reg

Interface
REQ-001 SHALL have parameter N, default 2: number of product fields, legal 2..16.
REQ-002 SHALL have parameter W, default 8: bit width of each field, legal 1..32.
REQ-003 SHALL have parameter INIT, default 0: W-bit reset value loaded into every field.
REQ-004 SHALL have parameter BYPASS, default 1: 1 = O shows next-cycle active state combinationally; 0 = O shows the registered active state.
REQ-005 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port wr_valid  input  1  field-write request.
REQ-008 SHALL have port wr_idx  input  IW = max(1,clog2(N))  target field index.
REQ-009 SHALL have port wr_data  input  W  value for the target field.
REQ-010 SHALL have port commit  input  1  copy staging bank to active bank.
REQ-011 SHALL have port rd_idx  input  IW  staging-bank read index.
REQ-012 SHALL have port O  output  N*W  active fields, field i at bits [i*W +: W].
REQ-013 SHALL have port rd_data  output  W  staging field read result.
REQ-014 SHALL have port dirty  output  N  per-field "staged but not committed" flags.
REQ-015 SHALL have port commit_done  output  1  one-cycle pulse after a commit.
REQ-016 SHALL have port idx_err  output  1  sticky out-of-range index flag.

Function
REQ-017 SHALL hold two N x W banks: staging (stage[i]) and active (active[i]).
REQ-018 Write fires when wr_valid=1 and wr_idx<N: stage[wr_idx] <= wr_data next edge; other fields unchanged.
REQ-019 A fired write without commit in the same cycle SHALL set dirty[wr_idx]=1.
REQ-020 wr_valid=1 with wr_idx>=N SHALL modify no state except setting idx_err=1.
REQ-021 commit=1 SHALL load active[i] <= stage[i] for all i at the next edge; latency 1 cycle.
REQ-022 Write and commit in the same cycle SHALL merge: active[wr_idx] <= wr_data and stage[wr_idx] <= wr_data.
REQ-023 commit=1 SHALL clear all dirty bits at the next edge, including the bit for any write in the same cycle.
REQ-024 commit_done SHALL be 1 exactly in the cycle after a cycle with commit=1; back-to-back commits SHALL give back-to-back pulses.
REQ-025 BYPASS=1: O SHALL equal the value active will hold after the current edge, i.e. the REQ-021/022 merge result when commit=1, else active.
REQ-026 BYPASS=0: O SHALL equal the active registers.
REQ-027 rd_data SHALL be registered: one cycle after rd_idx=k it SHALL show stage[k] as updated by that edge (write-first).
REQ-028 rd_idx>=N SHALL give rd_data=0 and SHALL set idx_err=1.
REQ-029 idx_err SHALL stay 1 until RESET.
REQ-030 The block SHALL have no state machine beyond the banks, dirty mask, commit_done and idx_err flops.

Reset
REQ-031 RESET=1 at an edge SHALL set stage[i]=active[i]=INIT, dirty=0, commit_done=0, rd_data=0 and idx_err=0.
REQ-032 RESET SHALL take priority over a write and over a commit in the same cycle; both are discarded.
REQ-033 With BYPASS=1 and RESET=1, O SHALL show {N{INIT}} combinationally in that cycle.
REQ-034 Reset in the cycle after a commit SHALL still drop commit_done to 0 at the next edge.

Verification
REQ-035 Settings N=2, W=8, INIT=0, BYPASS=1: write idx1=0x5A, then commit -> dirty=2'b10 after the write; O=0x5A00 during the commit cycle; commit_done=1 the cycle after; dirty=0.
REQ-036 Settings N=4, W=8, BYPASS=0: stage fields 0..3 = 0x11,0x22,0x33,0x44, then commit together with a write idx2=0x99 -> O=0x44992211 one cycle after the commit; dirty=0.
REQ-037 Settings N=3: wr_idx=3, wr_data=0xFF -> all banks unchanged; idx_err=1 and stays 1 for 10 cycles; RESET clears it.
REQ-038 Back-to-back commits for 3 cycles with writes to idx0 = 1, 2, 3 -> O field0 goes 1, 2, 3 cycle by cycle; commit_done high 3 consecutive cycles.
REQ-039 INIT=0xA5, RESET asserted with write and commit in the same cycle -> all fields 0xA5, dirty=0, commit_done=0 the next cycle.
REQ-040 Write idx1=0x3C with rd_idx=1 in the same cycle -> rd_data=0x3C next cycle; rd_idx=N -> rd_data=0 and idx_err=1.
